// File: rtl/tli4970_spi_responder_if.sv
// SPI pins between the board's TLI4970 master and the sensor responder.
`timescale 1ns/1ps
interface tli4970_spi_responder_if;
   logic spi_clk;
   logic spi_cs;
   logic spi_miso;
   logic spi_miso_oe;

   modport master (output spi_clk, output spi_cs, input spi_miso, input spi_miso_oe);
   modport slave  (input spi_clk, input spi_cs, output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/tli4970_spi_responder.sv
// TLI4970 current-sensor impersonator: answers SPI reads with 16-bit sensor-value frames
// (even parity, ocd flag, 13-bit offset-binary current code) built from current_in.
`timescale 1ns/1ps
module tli4970_spi_responder #(
   parameter int OFFSET     = 4096,
   parameter int CODE_MAX   = 8191,
   parameter int FRAME_BITS = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [15:0]        current_in,
   input  logic                      ocd_in,
   tli4970_spi_responder_if.slave    spi,
   output logic                      frame_done,
   output logic                      frame_abort,
   output logic [15:0]               frame_count
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic signed [16:0] OFFSET_S   = 17'(OFFSET);
   localparam logic signed [16:0] CODE_MAX_S = 17'(CODE_MAX);
   localparam logic [4:0]         BITS_LAST  = 5'(FRAME_BITS);

   state_t      state, state_nxt;
   logic [15:0] shreg, shreg_nxt;
   logic [4:0]  bitcnt, bitcnt_nxt;
   logic        miso_q, miso_nxt;
   logic        oe_q, oe_nxt;
   logic        done_nxt, abort_nxt;
   logic [15:0] count_nxt;

   logic sclk_p0, sclk_p1, sclk_p2;
   logic cs_p0, cs_p1, cs_p2;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   // Returns {sat, code}: clamp the offset sum into the 13-bit code range.
   function automatic logic [13:0] sat_code(input logic signed [16:0] sum);
      if (sum < 17'sd0)
         return {1'b1, 13'd0};
      else if (sum > CODE_MAX_S)
         return {1'b1, 13'(CODE_MAX)};
      else
         return {1'b0, sum[12:0]};
   endfunction

   function automatic logic [15:0] build_frame(input logic signed [15:0] cur, input logic ocd);
      logic signed [16:0] sum;
      logic [13:0]        sc;
      logic [15:0]        f;
      sum   = $signed({cur[15], cur}) + OFFSET_S;
      sc    = sat_code(sum);
      f     = {1'b0, 1'b0, ocd | sc[13], sc[12:0]};
      f[14] = ^f[13:0];
      return f;
   endfunction

   // Stage p0/p1: two-FF synchronisers; p2: edge-detect history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_p0 <= 1'b0;
         sclk_p1 <= 1'b0;
         sclk_p2 <= 1'b0;
         cs_p0   <= 1'b0;
         cs_p1   <= 1'b0;
         cs_p2   <= 1'b0;
      end else begin
         sclk_p0 <= spi.spi_clk;
         sclk_p1 <= sclk_p0;
         sclk_p2 <= sclk_p1;
         cs_p0   <= spi.spi_cs;
         cs_p1   <= cs_p0;
         cs_p2   <= cs_p1;
      end
   end

   assign sclk_rise = sclk_p1 & ~sclk_p2;
   assign sclk_fall = ~sclk_p1 & sclk_p2;
   assign cs_rise   = cs_p1 & ~cs_p2;
   assign cs_fall   = ~cs_p1 & cs_p2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shreg       <= '0;
         bitcnt      <= '0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_nxt;
         shreg       <= shreg_nxt;
         bitcnt      <= bitcnt_nxt;
         miso_q      <= miso_nxt;
         oe_q        <= oe_nxt;
         frame_done  <= done_nxt;
         frame_abort <= abort_nxt;
         frame_count <= count_nxt;
      end
   end

   // CS edges are tested first so they win over a coincident SCLK edge.
   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      bitcnt_nxt = bitcnt;
      miso_nxt   = miso_q;
      oe_nxt     = oe_q;
      done_nxt   = 1'b0;
      abort_nxt  = 1'b0;
      count_nxt  = frame_count;
      case (state)
         IDLE: begin
            miso_nxt = 1'b0;
            oe_nxt   = 1'b0;
            if (cs_fall) begin
               shreg_nxt  = build_frame(current_in, ocd_in);
               bitcnt_nxt = '0;
               oe_nxt     = 1'b1;
               state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               abort_nxt = 1'b1;
               oe_nxt    = 1'b0;
               miso_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (sclk_rise) begin
               miso_nxt   = shreg[15];
               shreg_nxt  = {shreg[14:0], 1'b0};
               bitcnt_nxt = bitcnt + 5'd1;
            end else if (sclk_fall && bitcnt == BITS_LAST) begin
               done_nxt  = 1'b1;
               count_nxt = frame_count + 16'd1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (cs_rise) begin
               oe_nxt    = 1'b0;
               miso_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (sclk_rise) begin
               miso_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign spi.spi_miso    = miso_q;
   assign spi.spi_miso_oe = oe_q;

endmodule

// File: tb/tb_tli4970_spi_responder.sv
// Randomised SPI-master bench for the TLI4970 responder, checked against a frame-level model.
`timescale 1ns/1ps
module tb_tli4970_spi_responder;

   localparam int OFFSET   = 4096;
   localparam int CODE_MAX = 8191;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [15:0] current_in;
   logic               ocd_in;
   logic               frame_done;
   logic               frame_abort;
   logic [15:0]        frame_count;

   int vectors     = 0;
   int miscompares = 0;
   int done_seen   = 0;
   int abort_seen  = 0;
   logic [15:0] exp_count;

   tli4970_spi_responder_if spi ();

   tli4970_spi_responder dut (
      .clk         (clk),
      .reset       (reset),
      .current_in  (current_in),
      .ocd_in      (ocd_in),
      .spi         (spi),
      .frame_done  (frame_done),
      .frame_abort (frame_abort),
      .frame_count (frame_count)
   );

   always #31 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done)  done_seen  <= done_seen + 1;
      if (frame_abort) abort_seen <= abort_seen + 1;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sensor-value frame from the datasheet rules, computed with plain integer arithmetic.
   function automatic logic [15:0] model_frame(input logic signed [15:0] cur, input logic ocd);
      int          sum;
      int          code;
      logic        sat;
      logic [15:0] f;
      sum = int'(cur) + OFFSET;
      sat = 1'b0;
      code = sum;
      if (sum < 0) begin
         code = 0;
         sat  = 1'b1;
      end else if (sum > CODE_MAX) begin
         code = CODE_MAX;
         sat  = 1'b1;
      end
      f = 16'(code) & 16'h1FFF;
      if (ocd || sat) f = f | 16'h2000;
      if ((^f) == 1'b1) f = f | 16'h4000;
      return f;
   endfunction

   task automatic run_frame(input logic signed [15:0] cur, input logic ocd, input int nbits,
                            input string tag);
      int          half;
      int          d0, a0;
      logic [15:0] exp_f;
      logic [31:0] rx;
      logic [31:0] extra_mask;
      logic        oe_mid;
      half  = $urandom_range(5, 10);
      exp_f = model_frame(cur, ocd);
      rx    = '0;
      current_in = cur;
      ocd_in     = ocd;
      wait_clks(2);
      d0 = done_seen;
      a0 = abort_seen;
      spi.spi_cs = 1'b0;
      wait_clks(half);
      for (int i = 0; i < nbits; i++) begin
         spi.spi_clk = 1'b1;
         wait_clks(half);
         rx = {rx[30:0], spi.spi_miso};
         spi.spi_clk = 1'b0;
         if (i == 2) begin
            current_in = 16'($urandom);
            ocd_in     = ~ocd;
         end
         wait_clks(half);
      end
      wait_clks(4);
      oe_mid = spi.spi_miso_oe;
      spi.spi_cs = 1'b1;
      wait_clks(8);
      chk({tag, ".oe_mid"}, 32'(oe_mid), 32'd1);
      chk({tag, ".oe_after"}, 32'(spi.spi_miso_oe), 32'd0);
      if (nbits >= 16) begin
         exp_count = exp_count + 16'd1;
         chk({tag, ".data"}, rx >> (nbits - 16), 32'(exp_f));
         if (nbits > 16) begin
            extra_mask = (32'd1 << (nbits - 16)) - 32'd1;
            chk({tag, ".extra"}, rx & extra_mask, 32'd0);
         end
         chk({tag, ".done"}, 32'(done_seen - d0), 32'd1);
         chk({tag, ".abort"}, 32'(abort_seen - a0), 32'd0);
      end else begin
         chk({tag, ".partial"}, rx, 32'(exp_f >> (16 - nbits)));
         chk({tag, ".done"}, 32'(done_seen - d0), 32'd0);
         chk({tag, ".abort"}, 32'(abort_seen - a0), 32'd1);
      end
      chk({tag, ".count"}, 32'(frame_count), 32'(exp_count));
   endtask

   task automatic reset_mid_frame();
      int   d0;
      logic oe_seen;
      current_in = 16'sd300;
      ocd_in     = 1'b0;
      spi.spi_cs = 1'b0;
      wait_clks(8);
      for (int i = 0; i < 9; i++) begin
         spi.spi_clk = 1'b1;
         wait_clks(8);
         spi.spi_clk = 1'b0;
         wait_clks(8);
      end
      spi.spi_clk = 1'b1;
      reset = 1'b1;
      #1;
      chk("rst_mid.oe", 32'(spi.spi_miso_oe), 32'd0);
      chk("rst_mid.count", 32'(frame_count), 32'd0);
      exp_count = 16'd0;
      wait_clks(3);
      reset = 1'b0;
      d0 = done_seen;
      oe_seen = 1'b0;
      spi.spi_clk = 1'b0;
      wait_clks(8);
      for (int i = 0; i < 16; i++) begin
         spi.spi_clk = 1'b1;
         wait_clks(8);
         oe_seen |= spi.spi_miso_oe;
         spi.spi_clk = 1'b0;
         wait_clks(8);
         oe_seen |= spi.spi_miso_oe;
      end
      chk("rst_hold.oe", 32'(oe_seen), 32'd0);
      chk("rst_hold.done", 32'(done_seen - d0), 32'd0);
      spi.spi_cs = 1'b1;
      wait_clks(10);
   endtask

   logic signed [15:0] corner [10] = '{16'sd5000, -16'sd5000, -16'sd4096, -16'sd4097,
                                       16'sd4095, 16'sd4096, 16'sd32767, -16'sd32768,
                                       16'sd1, -16'sd1};

   initial begin
      reset       = 1'b1;
      current_in  = '0;
      ocd_in      = 1'b0;
      spi.spi_clk = 1'b0;
      spi.spi_cs  = 1'b1;
      exp_count   = 16'd0;
      wait_clks(4);
      chk("rst.miso", 32'(spi.spi_miso), 32'd0);
      chk("rst.oe", 32'(spi.spi_miso_oe), 32'd0);
      chk("rst.done", 32'(frame_done), 32'd0);
      chk("rst.abort", 32'(frame_abort), 32'd0);
      chk("rst.count", 32'(frame_count), 32'd0);
      reset = 1'b0;
      wait_clks(8);

      run_frame(16'sd0, 1'b0, 16, "zero");
      run_frame(16'sd100, 1'b1, 16, "ocd100");
      foreach (corner[k]) run_frame(corner[k], 1'b0, 16, $sformatf("corner%0d", k));

      run_frame(16'sd1234, 1'b0, 7, "abort7");
      run_frame(16'sd1234, 1'b0, 16, "after_abort");
      run_frame(-16'sd777, 1'b1, 20, "long20");

      for (int n = 0; n < 12; n++)
         run_frame(16'($urandom_range(0, 12000) - 6000), 1'($urandom),
                   $urandom_range(14, 20), $sformatf("rnd%0d", n));

      reset_mid_frame();
      run_frame(16'sd2500, 1'b0, 16, "after_reset");

      @(negedge clk);
      force dut.frame_count = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count;
      exp_count = 16'hFFFF;
      wait_clks(2);
      chk("preload.count", 32'(frame_count), 32'h0000FFFF);
      run_frame(-16'sd42, 1'b0, 16, "wrap");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
